// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the RAM stream reader: FSM state encoding.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Two-entry output buffer (head + tail registers); head drives the stream directly.
module reader_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_occ_c
);

  logic             r_head_valid;
  logic             r_tail_valid;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_pop;

  assign w_pop = i_pop & r_head_valid;

  // Tail is only ever occupied while head is; caller never pushes into a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_valid <= 1'b0;
      r_tail_valid <= 1'b0;
      r_head       <= '0;
      r_tail       <= '0;
    end else if (!r_head_valid) begin
      r_head_valid <= i_push;
      if (i_push) r_head <= i_data;
    end else if (w_pop) begin
      if (r_tail_valid) begin
        r_head       <= r_tail;
        r_tail_valid <= i_push;
        if (i_push) r_tail <= i_data;
      end else begin
        r_head_valid <= i_push;
        if (i_push) r_head <= i_data;
      end
    end else if (i_push) begin
      r_tail_valid <= 1'b1;
      r_tail       <= i_data;
    end
  end

  assign o_valid = r_head_valid;
  assign o_data  = r_head;
  assign o_occ_c = 2'(r_head_valid) + 2'(r_tail_valid);

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous RAM address range and streams the words out on valid/ready,
// hiding the RAM's one-cycle read latency behind a two-entry buffer.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] ram_read_address,
  input  logic [WIDTH-1:0]     ram_output_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data
);

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned LEN_BITS  = ADDR_BITS + 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [LEN_BITS-1:0]  r_rem_issue;
  logic [LEN_BITS-1:0]  r_rem_pop;
  logic [LEN_BITS-1:0]  w_rem_pop_nxt;
  logic                 r_inflight;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_issue;
  logic                 w_load;
  logic                 w_pop;
  logic [1:0]           w_occ;
  logic [2:0]           w_level;
  logic                 w_fifo_valid;
  logic [WIDTH-1:0]     w_fifo_data;

  assign w_pop         = w_fifo_valid & m_ready;
  assign w_level       = 3'(w_occ) + 3'(r_inflight);
  assign w_rem_pop_nxt = r_rem_pop - LEN_BITS'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus issue decision; a read is issued only if its word will have a slot.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (length == '0) ? ST_FINISH : ST_READ;
        end
      end
      ST_READ: begin
        if (r_rem_issue == '0) w_state_nxt = ST_DRAIN;
        else w_issue = (w_level < (3'(BUF_DEPTH) + 3'(w_pop)));
      end
      ST_DRAIN: begin
        if (w_rem_pop_nxt == '0) w_state_nxt = ST_FINISH;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_rem_issue <= '0;
      r_rem_pop   <= '0;
      r_inflight  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_load) begin
        r_addr      <= base_addr;
        r_rem_issue <= length;
        r_rem_pop   <= length;
      end else begin
        if (w_issue) begin
          r_addr      <= r_addr + ADDR_BITS'(1);
          r_rem_issue <= r_rem_issue - LEN_BITS'(1);
        end
        r_rem_pop <= w_rem_pop_nxt;
      end
      r_inflight <= w_issue;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_FINISH);
    end
  end

  // RAM data is tagged by the issue flag of the previous cycle.
  reader_skid_fifo #(
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (ram_output_data),
    .i_pop   (m_ready),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_occ_c (w_occ)
  );

  assign busy             = r_busy;
  assign done             = r_done;
  assign ram_read_address = r_addr;
  assign m_valid          = w_fifo_valid;
  assign m_data           = w_fifo_data;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: stimulus pushes expected words, monitor pops on handshake.
module tb_ram_stream_reader;

  localparam int WIDTH     = 8;
  localparam int ADDR_BITS = 10;
  localparam int DEPTH     = 1 << ADDR_BITS;
  localparam int TIMEOUT   = 5000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [ADDR_BITS-1:0] base_addr;
  logic [ADDR_BITS:0]   length;
  logic                 busy;
  logic                 done;
  logic [ADDR_BITS-1:0] ram_read_address;
  logic [WIDTH-1:0]     ram_output_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [WIDTH-1:0]     m_data;

  logic [WIDTH-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q [$];
  int addr_log [$];
  bit log_addr = 1'b0;
  bit prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  ram_stream_reader #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .base_addr        (base_addr),
    .length           (length),
    .busy             (busy),
    .done             (done),
    .ram_read_address (ram_read_address),
    .ram_output_data  (ram_output_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model, no read enable.
  always @(posedge clk) ram_output_data <= mem[ram_read_address];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: data order via scoreboard, stability during stalls, address trace.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_data", int'(m_data), int'(prev_data));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", int'(m_data), -1);
        else chk("data", int'(m_data), exp_q.pop_front());
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (log_addr && busy &&
          (addr_log.size() == 0 || addr_log[addr_log.size()-1] != int'(ram_read_address)))
        addr_log.push_back(int'(ram_read_address));
    end
  end

  function automatic logic rdy(input int mode, input int k);
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    case (mode)
      0:       return 1'b1;
      1:       return pat[k % 6] != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Runs one transfer; k_done = edges after the accepting edge until done is seen.
  task automatic run_xfer(input int base, input int len, input int mode, input bit dbl,
                          output int k_done, output int first_valid);
    int k;
    for (int i = 0; i < len; i++) exp_q.push_back((base + i) % DEPTH % 256);
    m_ready = rdy(mode, 0);
    @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_BITS'(base); length = (ADDR_BITS+1)'(len);
    @(posedge clk); #1;
    if (dbl) begin
      base_addr = ADDR_BITS'(100); length = (ADDR_BITS+1)'(7);
    end else begin
      start = 1'b0;
    end
    k = 0;
    first_valid = m_valid ? 0 : -1;
    while (!done && k < TIMEOUT) begin
      m_ready = rdy(mode, k + 1);
      @(posedge clk); #1;
      k++;
      if (m_valid && first_valid < 0) first_valid = k;
    end
    if (!done) chk("done_timeout", int'(done), 1);
    k_done = k;
    chk("busy_in_done", int'(busy), 1);
    chk("queue_empty_at_done", exp_q.size(), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse_width", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
  endtask

  int kd, fv;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_addr", int'(ram_read_address), 0);
    chk("rst_data", int'(m_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // base 5, length 4, full throughput
    run_xfer(5, 4, 0, 1'b0, kd, fv);
    chk("t1_first_valid", fv, 2);
    chk("t1_done_edge", kd, 6);

    // address wrap at the top of the RAM
    addr_log.delete();
    log_addr = 1'b1;
    run_xfer(1022, 4, 0, 1'b0, kd, fv);
    log_addr = 1'b0;
    chk("t2_addr_count", (addr_log.size() >= 4) ? 1 : 0, 1);
    if (addr_log.size() >= 4) begin
      chk("t2_addr0", addr_log[0], 1022);
      chk("t2_addr1", addr_log[1], 1023);
      chk("t2_addr2", addr_log[2], 0);
      chk("t2_addr3", addr_log[3], 1);
    end
    chk("t2_done_edge", kd, 6);

    // backpressure pattern 1,0,0,1,0,1,...
    run_xfer(200, 8, 1, 1'b0, kd, fv);
    chk("t3_first_valid", fv, 2);

    // zero length with a second start held during busy
    run_xfer(77, 0, 0, 1'b1, kd, fv);
    chk("t4_done_edge", kd, 0);
    chk("t4_no_valid", fv, -1);
    repeat (4) begin
      @(posedge clk); #1;
      chk("t4_idle_busy", int'(busy), 0);
      chk("t4_idle_valid", int'(m_valid), 0);
    end

    // reset while words are pending under backpressure
    m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = ADDR_BITS'(40); length = (ADDR_BITS+1)'(8);
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_pending_valid", int'(m_valid), 1);
    chk("t5_pending_data", int'(m_data), 40);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_valid", int'(m_valid), 0);
    chk("t5_rst_data", int'(m_data), 0);
    chk("t5_rst_addr", int'(ram_read_address), 0);
    chk("t5_rst_done", int'(done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_xfer(300, 3, 0, 1'b0, kd, fv);
    chk("t5_done_edge", kd, 5);

    // full-depth transfer: done seen L+2 edges after acceptance (L+3 cycles from start)
    run_xfer(0, 1024, 0, 1'b0, kd, fv);
    chk("t6_first_valid", fv, 2);
    chk("t6_done_edge", kd, 1026);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
